// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, legal key configurations, round-counter
// sizing and GF(2^8) arithmetic used by the datapath blocks.
package aes_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic bit legal_cfg(input int n, input int nr, input int nk);
    return (n == 128 && nr == 10 && nk == 4) ||
           (n == 192 && nr == 12 && nk == 6) ||
           (n == 256 && nr == 14 && nk == 8);
  endfunction

  function automatic int round_w(input int nr);
    return $clog2(nr + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as the multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_primitives.sv
// AES building blocks: SubBytes, ShiftRows, MixColumns, AddRoundKey and the key schedule.
// Block byte b (row b%4, column b/4) occupies bits [127-8b -: 8].
module subBytes
  import aes_pkg::*;
(
  input  logic [127:0] in,
  output logic [127:0] out
);
  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign out[8*b +: 8] = sbox(in[8*b +: 8]);
  end
endmodule

module shiftRows (
  input  logic [127:0] in,
  output logic [127:0] out
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign out[127-8*(r+4*c) -: 8] = in[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module mixColumns
  import aes_pkg::*;
(
  input  logic [127:0] in,
  output logic [127:0] out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = in[127-32*c -: 32];
    assign out[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end
endmodule

module addRoundKey (
  input  logic [127:0] in,
  input  logic [127:0] rkey,
  output logic [127:0] out
);
  assign out = in ^ rkey;
endmodule

module keyExpansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]      key,
  output logic [128*(Nr+1)-1:0] sched
);
  localparam int NW = 4 * (Nr + 1);

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Word 0 of the schedule lands in the MSBs, so round key r is sched[128*(Nr-r) +: 128].
  always_comb begin
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rcon;
    sched = '0;
    t     = '0;
    rcon  = 8'h01;
    for (int i = 0; i < Nk; i++) w[i] = key[32*(Nk-1-i) +: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) sched[128*(Nr+1)-1-32*i -: 32] = w[i];
  end
endmodule

// File: rtl/aes_round_unit.sv
// One combinational AES round; the final round bypasses MixColumns.
module aes_round_unit (
  input  logic [127:0] blk,
  input  logic [127:0] rkey,
  input  logic         final_rnd,
  output logic [127:0] result
);
  logic [127:0] sb, sr, mc, pre_key;

  subBytes  u_sub   (.in(blk), .out(sb));
  shiftRows u_shift (.in(sb),  .out(sr));
  mixColumns u_mix  (.in(sr),  .out(mc));

  assign pre_key = final_rnd ? sr : mc;

  addRoundKey u_ark (.in(pre_key), .rkey(rkey), .out(result));
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: initial key add on accept, then one round per clock,
// with the round-key schedule expanded combinationally from the latched key.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);
  localparam int RW = round_w(Nr);
  localparam logic [RW-1:0] LAST_RND = RW'(Nr);

  if (!legal_cfg(N, Nr, Nk)) begin : g_bad_cfg
    $error("aes_encrypt_iter: unsupported (N, Nr, Nk) combination");
  end

  logic [1:0]            state;
  logic [RW-1:0]         round_q;
  logic [127:0]          state_q;
  logic [N-1:0]          key_q;
  logic [128*(Nr+1)-1:0] sched;
  logic [127:0]          rkeys [Nr+1];
  logic [127:0]          rkey;
  logic [127:0]          rnd_out;
  logic                  final_rnd;

  keyExpansion #(.Nk(Nk), .Nr(Nr)) u_kexp (.key(key_q), .sched(sched));

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rkeys[r] = sched[128*(Nr-r) +: 128];
  end

  assign rkey      = rkeys[round_q];
  assign final_rnd = (round_q == LAST_RND);

  aes_round_unit u_round (
    .blk      (state_q),
    .rkey     (rkey),
    .final_rnd(final_rnd),
    .result   (rnd_out)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_q   <= key;
            state_q <= in ^ key[N-1 -: 128];
            round_q <= RW'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          state_q <= rnd_out;
          // Counter parks at the last round instead of wrapping.
          if (final_rnd) state <= DONE;
          else           round_q <= round_q + RW'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors for all key sizes, latency,
// backpressure, in-flight input changes, mid-run reset and back-to-back traffic.
module tb_aes_encrypt_iter;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, out_ready;
  logic         in_valid, in_valid192, in_valid256;
  logic [127:0] in_blk;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         in_ready, in_ready192, in_ready256;
  logic         out_valid, out_valid192, out_valid256;
  logic [127:0] out, out192, out256;

  aes_encrypt_iter u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_blk),
    .key(key128), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );
  aes_encrypt_iter #(.N(192), .Nr(12), .Nk(6)) u_dut192 (
    .clk(clk), .rst(rst), .in_valid(in_valid192), .in_ready(in_ready192), .in(in_blk),
    .key(key192), .out_valid(out_valid192), .out_ready(out_ready), .out(out192)
  );
  aes_encrypt_iter #(.N(256), .Nr(14), .Nk(8)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid256), .in_ready(in_ready256), .in(in_blk),
    .key(key256), .out_valid(out_valid256), .out_ready(out_ready), .out(out256)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: table S-box built by brute-force inverse search, byte-array rounds.
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[(b%4) + 4*(((b/4) + (b%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r != nr) begin
          s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] inv, sv, c63;
    int d128, d192, d256, lat;
    int accepted, delivered, last_del;
    bit took;
    logic [127:0] exp_q [$];
    logic [127:0] exp_v;

    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x] = sv;
    end
    chk("model_fips128", aes_ref(PT, {K128, 128'h0}, 4), CT128);

    // Reset state
    rst = 1'b1; out_ready = 1'b0;
    in_valid = 1'b0; in_valid192 = 1'b0; in_valid256 = 1'b0;
    in_blk = '0; key128 = '0; key192 = '0; key256 = '0;
    tick(); tick();
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", out, 128'h0);
    chk_int("rst_in_ready256", int'(in_ready256), 1);
    rst = 1'b0;

    // FIPS vectors on all three key sizes; delivery edge counted from the accept edge
    in_blk = PT; key128 = K128; key192 = K192; key256 = K256;
    in_valid = 1'b1; in_valid192 = 1'b1; in_valid256 = 1'b1;
    tick();
    in_valid = 1'b0; in_valid192 = 1'b0; in_valid256 = 1'b0;
    in_blk = rand128(); key128 = rand128(); key192 = {rand128(), 64'h0}; key256 = {rand128(), rand128()};
    d128 = 0; d192 = 0; d256 = 0;
    for (int e = 1; e <= 20; e++) begin
      if (out_valid    && d128 == 0) d128 = e;
      if (out_valid192 && d192 == 0) d192 = e;
      if (out_valid256 && d256 == 0) d256 = e;
      tick();
    end
    chk_int("latency128", d128, 11);
    chk_int("latency192", d192, 13);
    chk_int("latency256", d256, 15);
    chk("ct128", out, CT128);
    chk("ct192", out192, CT192);
    chk("ct256", out256, CT256);

    // Backpressure: held result, no new accept
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_stable", out, CT128);
      chk_int("bp_in_ready", int'(in_ready), 0);
      chk_int("bp_out_valid", int'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("bp_one_transfer", int'(out_valid), 0);
    chk_int("bp_ready_back", int'(in_ready), 1);
    chk_int("bp_ready_back256", int'(in_ready256), 1);

    // Inputs toggled while the block is in flight
    in_blk = PT; key128 = K128; in_valid = 1'b1;
    chk_int("flight_ready_pre", int'(in_ready), 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      in_blk = rand128(); key128 = rand128(); in_valid = 1'($urandom_range(0, 1));
      chk_int("flight_no_accept", int'(in_ready), 0);
      tick();
    end
    chk_int("flight_out_valid", int'(out_valid), 1);
    chk("flight_ct", out, CT128);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("flight_delivered", int'(out_valid), 0);
    tick();
    chk_int("flight_no_second", int'(out_valid), 0);
    chk_int("flight_idle", int'(in_ready), 1);

    // Reset at round 5
    in_blk = PT; key128 = K128; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_int("mid_rst_in_ready", int'(in_ready), 1);
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out", out, 128'h0);
    in_blk = PT; key128 = K128; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      if (out_valid) lat = e;
      else tick();
    end
    chk_int("post_rst_latency", lat, 11);
    chk("post_rst_ct", out, CT128);
    out_ready = 1'b1;
    tick();

    // Back-to-back random traffic against the reference model
    accepted = 0; delivered = 0; last_del = -1;
    in_blk = rand128(); key128 = rand128();
    for (int cyc = 0; cyc < 1400 && delivered < 100; cyc++) begin
      in_valid = (accepted < 100);
      took = 1'b0;
      if (in_ready && in_valid) begin
        exp_q.push_back(aes_ref(in_blk, {key128, 128'h0}, 4));
        accepted++;
        took = 1'b1;
      end
      if (out_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk("b2b_ct", out, exp_v);
        if (last_del >= 0) chk_int("b2b_spacing", cyc - last_del, 12);
        last_del = cyc;
        delivered++;
      end
      tick();
      if (took) begin
        in_blk = rand128(); key128 = rand128();
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_int("b2b_delivered", delivered, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter N, default 128: key width in bits; legal values are 128, 192 and 256.
REQ-002 SHALL have parameter Nr, default 10: round count; legal values are 10, 12 and 14.
REQ-003 SHALL have parameter Nk, default 4: key words; legal values are 4, 6 and 8.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 SHALL provide port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL provide port in_valid, input, 1 bit: the in/key pair is valid.
REQ-008 SHALL provide port in_ready, output, 1 bit: the core can accept a block.
REQ-009 SHALL provide port in, input, 128 bits: plaintext block.
REQ-010 SHALL provide port key, input, N bits: cipher key.
REQ-011 SHALL provide port out_valid, output, 1 bit: out holds a finished ciphertext.
REQ-012 SHALL provide port out_ready, input, 1 bit: the sink accepts out.
REQ-013 SHALL provide port out, output, 128 bits: ciphertext block.

Function
REQ-014 SHALL produce FIPS-197 AES ciphertext for the configured key size, processing one round per clock cycle.
REQ-015 SHALL implement states IDLE, RUN and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-016 SHALL, in IDLE, accept a block on a cycle where in_valid&&in_ready, performing these actions on that edge:
- latch key into key_q;
- state_q <= in ^ key[N-1 -: 128];
- round_q <= 1;
- move to RUN.
REQ-017 SHALL, in RUN with round_q<Nr, perform a full round on state_q: SubBytes, ShiftRows, MixColumns, then AddRoundKey with round key round_q; it then increments round_q.
REQ-018 SHALL, in RUN with round_q==Nr, perform the final round without MixColumns, then move to DONE.
REQ-019 SHALL derive round key r from key_q through the expanded schedule: 128*(Nr+1) bits, with round key 0 in the MSBs and round key Nr in bits [127:0].
REQ-020 SHALL assert out_valid exactly Nr+1 rising edges after the accepting edge, so throughput is one block per Nr+2 cycles without backpressure.
REQ-021 SHALL drive out from state_q, and out SHALL remain stable while out_valid&&!out_ready.
REQ-022 SHALL, in DONE, return to IDLE on the edge where out_ready is high; in_ready rises on the following cycle, with no same-cycle accept/deliver overlap.
REQ-023 SHALL ignore in_valid while in RUN or DONE; in, key and in_valid changes there SHALL NOT affect the block in flight.
REQ-024 SHALL hold round_q as ceil(log2(Nr+1)) bits; round_q SHALL never exceed Nr and SHALL NOT wrap.
REQ-025 SHALL not be required to hold in and key stable after the accepting edge.
REQ-026 SHALL cause an elaboration error for any (N, Nr, Nk) other than (128,10,4), (192,12,6) or (256,14,8).

Reset
REQ-027 SHALL, while rst is high at a clock edge, set state to IDLE, round_q to 0, state_q to 0 and key_q to 0.
REQ-028 SHALL, out of reset, drive in_ready=1, out_valid=0 and out=128'h0.
REQ-029 SHALL, when rst is asserted mid-RUN or in DONE, discard the in-flight block with no out_valid pulse; the first accept SHALL be possible on the cycle after rst deasserts.

Structure
REQ-030 SHALL place in a shared package aes_pkg:
- the state encoding (IDLE/RUN/DONE);
- the legal (N, Nr, Nk) triples;
- a round-counter width function.
REQ-031 SHALL contain one sub-module, aes_round_unit: a combinational round with a final-round select that bypasses MixColumns, built from the existing subBytes, shiftRows, mixColumns and addRoundKey blocks.
REQ-032 SHALL reuse the existing keyExpansion block, instantiated on key_q, to generate the round-key schedule.

Verification
REQ-033 SHALL cover AES-128: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid at edge 11 after accept.
REQ-034 SHALL cover AES-192 and AES-256 with the same plaintext:
- N=192, key 000102...1617 -> dda97ca4864cdfe06eaf70a0ec0d7191, out_valid at edge 13;
- N=256, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089, out_valid at edge 15.
REQ-035 SHALL cover backpressure: hold out_ready=0 for 20 cycles after out_valid -> out stable, in_ready=0 throughout, and one transfer when out_ready rises.
REQ-036 SHALL cover input changes in flight: toggle in, key and in_valid randomly during RUN -> ciphertext equals the REQ-033 vector, with no second accept.
REQ-037 SHALL cover reset mid-operation: rst at round 5 -> next cycle in_ready=1, out_valid=0, out=0; the next block encrypts correctly.
REQ-038 SHALL cover back-to-back traffic: 100 random blocks with in_valid and out_ready held at 1 -> every result matches a reference model, with blocks spaced exactly Nr+2 cycles apart.
